// File: rtl/clock_time_set.sv
// 24-hour BCD timekeeping core driven by a 1 Hz enable pulse, with synchronized and
// debounced mode/increment buttons for setting hours and minutes.
module clock_time_set #(
    parameter int unsigned DB_CYCLES = 20
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] d0_min_out,
    output logic [3:0] d1_min_out,
    output logic [3:0] d0_h_out,
    output logic [3:0] d1_h_out,
    output logic [1:0] mode
);
    localparam int BtnMode = 0;
    localparam int BtnInc  = 1;
    localparam logic [9:0] DbLast = 10'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetH   = 2'd1,
        StSetMin = 2'd2
    } state_e;

    logic [1:0] btn_raw;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] level_q, level_d;
    logic [1:0] prev_q, press_q;
    logic [9:0] cnt_q [2];
    logic [9:0] cnt_d [2];

    state_e     state_q, state_d;
    logic [5:0] sec_q, sec_d;
    logic [3:0] min0_q, min0_d, min1_q, min1_d;
    logic [3:0] hr0_q, hr0_d, hr1_q, hr1_d;
    logic       min_inc, hr_inc;

    assign btn_raw = {btn_inc, btn_mode};

    // Accepted level flips only after DB_CYCLES consecutive differing samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i] = level_q[i];
            cnt_d[i]   = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            prev_q  <= '0;
            press_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min0_d  = min0_q;
        min1_d  = min1_q;
        hr0_d   = hr0_q;
        hr1_d   = hr1_q;
        min_inc = 1'b0;
        hr_inc  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (tick_1hz) begin
                    if (sec_q == 6'd59) begin
                        sec_d   = '0;
                        min_inc = 1'b1;
                        hr_inc  = (min1_q == 4'd5) && (min0_q == 4'd9);
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
                if (press_q[BtnMode]) state_d = StSetH;
            end
            StSetH: begin
                hr_inc = press_q[BtnInc];
                if (press_q[BtnMode]) state_d = StSetMin;
            end
            StSetMin: begin
                min_inc = press_q[BtnInc];
                if (press_q[BtnMode]) begin
                    state_d = StRun;
                    sec_d   = '0;
                end
            end
            default: state_d = StRun;
        endcase

        // Minutes wrap 59 -> 00 on their own; the hours carry is decided above.
        if (min_inc) begin
            if (min0_q == 4'd9) begin
                min0_d = '0;
                min1_d = (min1_q == 4'd5) ? 4'd0 : min1_q + 4'd1;
            end else begin
                min0_d = min0_q + 4'd1;
            end
        end

        if (hr_inc) begin
            if (hr1_q == 4'd2 && hr0_q == 4'd3) begin
                hr1_d = '0;
                hr0_d = '0;
            end else if (hr0_q == 4'd9) begin
                hr0_d = '0;
                hr1_d = hr1_q + 4'd1;
            end else begin
                hr0_d = hr0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            sec_q   <= '0;
            min0_q  <= '0;
            min1_q  <= '0;
            hr0_q   <= '0;
            hr1_q   <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min0_q  <= min0_d;
            min1_q  <= min1_d;
            hr0_q   <= hr0_d;
            hr1_q   <= hr1_d;
        end
    end

    assign d0_min_out = min0_q;
    assign d1_min_out = min1_q;
    assign d0_h_out   = hr0_q;
    assign d1_h_out   = hr1_q;
    assign mode       = state_q;

endmodule

// File: tb/tb_clock_time_set.sv
// Bench for clock_time_set: a time/press-window model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_clock_time_set;
    localparam int unsigned DB = 4;

    logic       clk_in   = 1'b0;
    logic       rst      = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [3:0] d0_min_out, d1_min_out, d0_h_out, d1_h_out;
    logic [1:0] mode;

    int total = 0;
    int bad   = 0;

    clock_time_set #(.DB_CYCLES(DB)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .d0_min_out (d0_min_out),
        .d1_min_out (d1_min_out),
        .d0_h_out   (d0_h_out),
        .d1_h_out   (d1_h_out),
        .mode       (mode)
    );

    always #5 clk_in = ~clk_in;

    // Model: time as integers, presses derived from a window over raw-button history.
    int m_h, m_m, m_s, m_st;
    int n;
    int acc [2];
    int due [2];
    bit hist_mode [$];
    bit hist_inc [$];

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_st = 0; n = 0;
        acc[0] = 0; acc[1] = 0;
        due[0] = -1; due[1] = -1;
        hist_mode.delete();
        hist_inc.delete();
    endtask

    // Synchronized sample seen by the debouncer at edge e is the raw level from edge e-2.
    function automatic int sample(int b, int e);
        if (e < 2) return 0;
        return (b == 0) ? int'(hist_mode[e-2]) : int'(hist_inc[e-2]);
    endfunction

    task automatic model_step();
        bit mp, ip, flip;
        int t;
        mp = (due[0] == n);
        ip = (due[1] == n);
        hist_mode.push_back(btn_mode);
        hist_inc.push_back(btn_inc);
        for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int k = 0; k < int'(DB); k++) begin
                if (sample(b, n - k) == acc[b]) flip = 1'b0;
            end
            if (flip) begin
                acc[b] = 1 - acc[b];
                if (acc[b] == 1) due[b] = n + 2;
            end
        end
        case (m_st)
            0: begin
                if (tick_1hz) begin
                    t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = t / 3600;
                    m_m = (t / 60) % 60;
                    m_s = t % 60;
                end
                if (mp) m_st = 1;
            end
            1: begin
                if (ip) m_h = (m_h + 1) % 24;
                if (mp) m_st = 2;
            end
            default: begin
                if (ip) m_m = (m_m + 1) % 60;
                if (mp) begin
                    m_st = 0;
                    m_s  = 0;
                end
            end
        endcase
        n++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        logic [17:0] got, exp;
        forever begin
            @(negedge clk_in);
            if (!rst) begin
                exp = {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10), 2'(m_st)};
                got = {d1_h_out, d0_h_out, d1_min_out, d0_min_out, mode};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL cycle_model t=%0t: got h=%0d%0d m=%0d%0d mode=%0d expected h=%0d%0d m=%0d%0d mode=%0d",
                             $time, got[17:14], got[13:10], got[9:6], got[5:2], got[1:0],
                             exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1:0]);
                end
            end
        end
    end

    task automatic check_lit(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Literal expectations on both the DUT and the model.
    task automatic check_time(input string name, input int hh, input int mm, input int md);
        check_lit({name, "_dut_hours"}, int'(d1_h_out) * 10 + int'(d0_h_out), hh);
        check_lit({name, "_dut_mins"}, int'(d1_min_out) * 10 + int'(d0_min_out), mm);
        check_lit({name, "_dut_mode"}, int'(mode), md);
        check_lit({name, "_model_hours"}, m_h, hh);
        check_lit({name, "_model_mins"}, m_m, mm);
        check_lit({name, "_model_mode"}, m_st, md);
    endtask

    task automatic ticks(input int k);
        repeat (k) begin
            @(negedge clk_in);
            tick_1hz = 1'b1;
        end
        @(negedge clk_in);
        tick_1hz = 1'b0;
    endtask

    task automatic press(input int b);
        @(negedge clk_in);
        if (b == 0) btn_mode = 1'b1;
        else btn_inc = 1'b1;
        repeat (DB + 6) @(negedge clk_in);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (DB + 6) @(negedge clk_in);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk_in);
        check_time("reset", 0, 0, 0);
        rst = 1'b0;

        ticks(60);
        check_time("run_60", 0, 1, 0);
        ticks(3540);
        check_time("run_3600", 1, 0, 0);

        // Preload 23:59:58 then cross midnight.
        press(0);
        check_time("enter_set_h", 1, 0, 1);
        repeat (22) press(1);
        press(0);
        repeat (59) press(1);
        press(0);
        check_time("preload", 23, 59, 0);
        ticks(58);
        check_time("preload_58", 23, 59, 0);
        ticks(2);
        check_time("midnight", 0, 0, 0);

        // Set sequence with ticks ignored in both set states.
        press(0);
        ticks(10);
        check_time("tick_in_set_h", 0, 0, 1);
        repeat (25) press(1);
        check_time("hours_25", 1, 0, 1);
        press(0);
        ticks(10);
        check_time("tick_in_set_min", 1, 0, 2);
        repeat (61) press(1);
        check_time("mins_61", 1, 1, 2);
        press(0);
        check_time("back_to_run", 1, 1, 0);
        ticks(59);
        check_time("sec_cleared", 1, 1, 0);
        ticks(1);
        check_time("run_after_set", 1, 2, 0);

        // Bounce of period 4 produces nothing; a steady hold gives one press at +7.
        press(0);
        for (int i = 0; i < 20; i++) begin
            btn_inc = (i % 2 == 0);
            repeat (2) @(negedge clk_in);
        end
        check_time("bounce", 1, 2, 1);
        btn_inc = 1'b1;
        repeat (7) @(negedge clk_in);
        check_time("hold_6", 1, 2, 1);
        @(negedge clk_in);
        check_time("hold_7", 2, 2, 1);
        repeat (20) @(negedge clk_in);
        check_time("no_repeat", 2, 2, 1);
        btn_inc = 1'b0;
        repeat (DB + 6) @(negedge clk_in);

        // Reach 12:34:59, then tick coincident with the mode press.
        repeat (10) press(1);
        press(0);
        repeat (32) press(1);
        press(0);
        ticks(59);
        check_time("pre_coincide", 12, 34, 0);
        @(negedge clk_in);
        btn_mode = 1'b1;
        repeat (7) @(negedge clk_in);
        tick_1hz = 1'b1;
        @(negedge clk_in);
        tick_1hz = 1'b0;
        check_time("coincide", 12, 35, 1);
        btn_mode = 1'b0;
        repeat (DB + 6) @(negedge clk_in);

        // Reset in the middle of a mode debounce while in SET_MIN.
        press(0);
        check_time("pre_reset", 12, 35, 2);
        btn_mode = 1'b1;
        repeat (4) @(negedge clk_in);
        #2 rst = 1'b1;
        #1 check_time("async_reset", 0, 0, 0);
        btn_mode = 1'b0;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        repeat (20) @(negedge clk_in);
        check_time("no_spurious", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
